// File: rtl/cpu_pkg.sv
// Shared core definitions: PC command priority encoding and default address width.
// Used by the PC unit and by the controller that drives it.
package cpu_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    PC_CMD_NONE,
    PC_CMD_INC,
    PC_CMD_BRANCH,
    PC_CMD_LOAD,
    PC_CMD_CALL,
    PC_CMD_RET,
    PC_CMD_RST
  } pc_cmd_e;

  // Fixed priority: reset > ret > call > load > branch > increment.
  function automatic pc_cmd_e pc_cmd_decode(input logic rst, input logic ret,
                                            input logic call, input logic load,
                                            input logic branch, input logic inc);
    pc_cmd_e cmd;
    cmd = PC_CMD_NONE;
    if (rst)         cmd = PC_CMD_RST;
    else if (ret)    cmd = PC_CMD_RET;
    else if (call)   cmd = PC_CMD_CALL;
    else if (load)   cmd = PC_CMD_LOAD;
    else if (branch) cmd = PC_CMD_BRANCH;
    else if (inc)    cmd = PC_CMD_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// PC bus between the controller (master) and the program-counter unit (slave).
interface pc_stack_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4
) ();

  logic                             reset;
  logic                             ret;
  logic                             call;
  logic                             load;
  logic                             branch;
  logic                             increment;
  logic [ADDR_WIDTH-1:0]            load_data;
  logic [ADDR_WIDTH-1:0]            offset;
  logic [ADDR_WIDTH-1:0]            counter;
  logic [$clog2(STACK_DEPTH+1)-1:0] stack_level;
  logic                             out_of_range;
  logic                             stack_overflow;
  logic                             stack_underflow;

  modport master (
    output reset, ret, call, load, branch, increment, load_data, offset,
    input  counter, stack_level, out_of_range, stack_overflow, stack_underflow
  );

  modport slave (
    input  reset, ret, call, load, branch, increment, load_data, offset,
    output counter, stack_level, out_of_range, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/pc_stack_unit_return_stack.sv
// Return-address LIFO: DEPTH entries of WIDTH bits, level-tracked, sync active-low reset.
module return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       s_reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign top_data = mem[IW'(level - 1'b1)];

  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + 1'b1;
    end else if (pop && !empty) begin
      level <= level - 1'b1;
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (s_reset_n && push && !full) begin
      mem[IW'(level)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter unit: absolute load, signed relative branch, call/return via a
// hardware return stack, with sticky range/overflow/underflow flags.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PC_LIMIT    = 2**ADDR_WIDTH - 1
) (
  input logic            clk,
  input logic            s_reset_n,
  pc_stack_unit_if.slave bus
);

  localparam int unsigned XW = ADDR_WIDTH + 2;
  localparam logic [XW-1:0] LIMIT_X = XW'(PC_LIMIT);

  pc_cmd_e               cmd;
  logic [ADDR_WIDTH-1:0] counter_q;
  logic                  oor_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic [XW-1:0]         cnt_ext;
  logic [XW-1:0]         ld_ext;
  logic [XW-1:0]         br_target;
  logic                  at_limit;
  logic                  ld_bad;
  logic                  br_bad;

  logic                  st_push;
  logic                  st_pop;
  logic                  st_rst_n;
  logic [ADDR_WIDTH-1:0] st_top;
  logic                  st_full;
  logic                  st_empty;
  logic [$clog2(STACK_DEPTH+1)-1:0] st_level;

  assign cmd = pc_cmd_decode(bus.reset, bus.ret, bus.call, bus.load,
                             bus.branch, bus.increment);

  // Range checks are done two bits wider so neither overflow nor a negative
  // branch target can wrap back into the legal window.
  always_comb begin
    cnt_ext   = {2'b00, counter_q};
    ld_ext    = {2'b00, bus.load_data};
    br_target = cnt_ext + {{2{bus.offset[ADDR_WIDTH-1]}}, bus.offset};
    at_limit  = (cnt_ext >= LIMIT_X);
    ld_bad    = (ld_ext > LIMIT_X);
    br_bad    = (br_target > LIMIT_X);
  end

  assign st_rst_n = s_reset_n && (cmd != PC_CMD_RST);
  assign st_push  = s_reset_n && (cmd == PC_CMD_CALL) && !st_full && !at_limit && !ld_bad;
  assign st_pop   = s_reset_n && (cmd == PC_CMD_RET) && !st_empty;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_return_stack (
    .clk       (clk),
    .s_reset_n (st_rst_n),
    .push      (st_push),
    .pop       (st_pop),
    .push_data (counter_q + 1'b1),
    .top_data  (st_top),
    .full      (st_full),
    .empty     (st_empty),
    .level     (st_level)
  );

  always_ff @(posedge clk) begin
    if (!s_reset_n || cmd == PC_CMD_RST) begin
      counter_q <= '0;
      oor_q     <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      case (cmd)
        PC_CMD_RET: begin
          if (st_empty) udf_q     <= 1'b1;
          else          counter_q <= st_top;
        end
        PC_CMD_CALL: begin
          if (st_full)                 ovf_q     <= 1'b1;
          else if (at_limit || ld_bad) oor_q     <= 1'b1;
          else                         counter_q <= bus.load_data;
        end
        PC_CMD_LOAD: begin
          if (ld_bad) oor_q     <= 1'b1;
          else        counter_q <= bus.load_data;
        end
        PC_CMD_BRANCH: begin
          if (br_bad) oor_q     <= 1'b1;
          else        counter_q <= br_target[ADDR_WIDTH-1:0];
        end
        PC_CMD_INC: begin
          if (at_limit) oor_q     <= 1'b1;
          else          counter_q <= counter_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.counter         = counter_q;
  assign bus.stack_level     = st_level;
  assign bus.out_of_range    = oor_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = udf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: queue-based PC/stack model checked every cycle,
// plus literal expectations that pin the model.
module tb_pc_stack_unit;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 255;

  logic clk = 1'b0;
  logic s_reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_stack_unit_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) bus ();

  pc_stack_unit #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (DEPTH),
    .PC_LIMIT    (LIMIT)
  ) dut (
    .clk       (clk),
    .s_reset_n (s_reset_n),
    .bus       (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  int m_pc = 0;
  int m_stk[$];
  bit m_oor = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  task automatic model(input bit hard_rst, input bit rst, input bit r, input bit c,
                       input bit l, input bit b, input bit i, input int ld, input int off);
    int t;
    if (hard_rst || rst) begin
      m_pc = 0; m_stk.delete(); m_oor = 0; m_ovf = 0; m_udf = 0;
    end else if (r) begin
      if (m_stk.size() == 0) m_udf = 1;
      else m_pc = m_stk.pop_back();
    end else if (c) begin
      if (m_stk.size() == DEPTH) m_ovf = 1;
      else if (m_pc == LIMIT || ld > LIMIT) m_oor = 1;
      else begin m_stk.push_back(m_pc + 1); m_pc = ld; end
    end else if (l) begin
      if (ld > LIMIT) m_oor = 1; else m_pc = ld;
    end else if (b) begin
      t = m_pc + ((off >= 128) ? off - 256 : off);
      if (t < 0 || t > LIMIT) m_oor = 1; else m_pc = t;
    end else if (i) begin
      if (m_pc == LIMIT) m_oor = 1; else m_pc = m_pc + 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (bus.counter !== AW'(m_pc) || bus.stack_level !== 3'(m_stk.size()) ||
          bus.out_of_range !== m_oor || bus.stack_overflow !== m_ovf ||
          bus.stack_underflow !== m_udf) begin
        miscompares++;
        $display("FAIL cycle t=%0t counter=%h exp=%h level=%0d exp=%0d oor=%b exp=%b ovf=%b exp=%b udf=%b exp=%b",
                 $time, bus.counter, AW'(m_pc), bus.stack_level, m_stk.size(),
                 bus.out_of_range, m_oor, bus.stack_overflow, m_ovf, bus.stack_underflow, m_udf);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit r, input bit c, input bit l,
                      input bit b, input bit i, input int ld, input int off);
    bus.reset = rst; bus.ret = r; bus.call = c; bus.load = l;
    bus.branch = b; bus.increment = i;
    bus.load_data = AW'(ld); bus.offset = AW'(off);
    @(posedge clk);
    model(!s_reset_n, rst, r, c, l, b, i, ld, off);
    @(negedge clk);
  endtask

  task automatic hard_reset();
    s_reset_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    s_reset_n = 1'b1;
  endtask

  task automatic inc();           step(0, 0, 0, 0, 0, 1, 0, 0);   endtask
  task automatic ld(input int a); step(0, 0, 0, 1, 0, 0, a, 0);   endtask
  task automatic br(input int o); step(0, 0, 0, 0, 1, 0, 0, o);   endtask
  task automatic cl(input int a); step(0, 0, 1, 0, 0, 0, a, 0);   endtask
  task automatic rt();            step(0, 1, 0, 0, 0, 0, 0, 0);   endtask
  task automatic sr();            step(1, 0, 0, 0, 0, 0, 0, 0);   endtask

  initial begin
    @(negedge clk);
    hard_reset();
    chk_en = 1'b1;
    lit("reset_counter", bus.counter, 0);
    lit("reset_level", bus.stack_level, 0);
    lit("reset_flags", {bus.out_of_range, bus.stack_overflow, bus.stack_underflow}, 0);

    // 1: increments
    inc(); lit("inc1", bus.counter, 1);
    inc(); lit("inc2", bus.counter, 2);
    inc(); lit("inc3", bus.counter, 3);

    // 2: branches
    ld(10); br(8'hFB); lit("br_back", bus.counter, 5);
    br(8'h10); lit("br_fwd", bus.counter, 8'h15);
    ld(3); br(8'hFB); lit("br_neg_hold", bus.counter, 3);
    lit("br_neg_oor", bus.out_of_range, 1);
    ld(8'hF0); br(8'h7F); lit("br_hi_hold", bus.counter, 8'hF0);

    // 3: nested call/return
    sr();
    lit("soft_reset_oor", bus.out_of_range, 0);
    ld(8'h20); cl(8'h80); cl(8'h90);
    lit("call2_counter", bus.counter, 8'h90);
    lit("call2_level", bus.stack_level, 2);
    rt(); lit("ret1", bus.counter, 8'h81);
    rt(); lit("ret2", bus.counter, 8'h21);
    lit("ret2_level", bus.stack_level, 0);

    // 4: overflow then underflow
    hard_reset();
    ld(8'h10);
    for (int k = 0; k < 5; k++) cl(8'h20 + 8'h10 * k);
    lit("ovf_level", bus.stack_level, 4);
    lit("ovf_counter", bus.counter, 8'h50);
    lit("ovf_flag", bus.stack_overflow, 1);
    for (int k = 0; k < 4; k++) rt();
    lit("unwind_counter", bus.counter, 8'h11);
    rt(); lit("udf_flag", bus.stack_underflow, 1);
    lit("udf_counter", bus.counter, 8'h11);

    // 5: upper limit
    sr();
    ld(8'hFF); inc();
    lit("limit_hold", bus.counter, 8'hFF);
    lit("limit_oor", bus.out_of_range, 1);
    cl(8'h10); lit("limit_call_level", bus.stack_level, 0);
    ld(8'h10); lit("limit_reload", bus.counter, 8'h10);
    lit("oor_sticky", bus.out_of_range, 1);

    // 6: priority
    sr();
    ld(8'h05);
    step(0, 0, 1, 1, 0, 1, 8'h40, 0);
    lit("prio_call_level", bus.stack_level, 1);
    rt(); lit("prio_ret", bus.counter, 8'h06);
    ld(8'h30);
    step(1, 0, 1, 0, 0, 0, 8'h70, 0);
    lit("rst_call_counter", bus.counter, 0);
    lit("rst_call_level", bus.stack_level, 0);
    rt(); lit("rst_call_nopush", bus.stack_underflow, 1);
    step(0, 1, 1, 0, 0, 0, 8'h44, 0);
    lit("ret_over_call", bus.counter, 0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
